// File: rtl/im_pkg.sv
// rtl/im_pkg.sv - shared instruction-memory constants and loader state encoding
package im_pkg;

  localparam int IM_MEM_SIZE = 128;
  localparam int IM_WORDS    = IM_MEM_SIZE / 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CSUM,
    DONE
  } loader_state_t;

endpackage

// File: rtl/im_word_packer.sv
// rtl/im_word_packer.sv - big-endian 4-byte packing register with byte counter
module im_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt,
  output logic        complete
);

  // The byte being shifted now is the fourth of its word.
  assign complete = shift && (byte_cnt == 2'd3);

  // Shift each accepted byte in at the bottom so the first byte ends up in [31:24].
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (shift) begin
      word     <= {word[23:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - framed byte-stream loader writing big-endian words into IM
module im_loader
  import im_pkg::*;
#(
  parameter int MEM_SIZE = IM_MEM_SIZE,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  localparam int         WIDX_W = ADDR_W - 2;
  localparam logic [7:0] MAX_L  = 8'(MEM_SIZE / 4);

  loader_state_t     state, state_n;
  logic [WIDX_W-1:0] word_idx, word_idx_n;
  logic [WIDX_W-1:0] len_m1, len_m1_n;
  logic [7:0]        acc, acc_n;
  logic              err_n, busy_n, done_n, hold_n, mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [31:0]       mem_wdata_n;

  logic              xfer;
  logic              pk_clear, pk_shift, pk_complete;
  logic [31:0]       pk_word;
  logic [1:0]        pk_cnt;

  // Ready depends on the registered state only, so it never combinationally follows in_valid.
  assign in_ready = (state == LEN) || (state == DATA) || (state == CSUM);
  assign xfer     = in_valid && in_ready;
  assign pk_shift = xfer && (state == DATA);

  im_word_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pk_clear),
    .shift    (pk_shift),
    .byte_in  (in_data),
    .word     (pk_word),
    .byte_cnt (pk_cnt),
    .complete (pk_complete)
  );

  // Next-state and next-output decode; every registered output is computed here.
  always_comb begin
    state_n     = state;
    word_idx_n  = word_idx;
    len_m1_n    = len_m1;
    acc_n       = acc;
    err_n       = err;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    pk_clear    = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n    = LEN;
          err_n      = 1'b0;
          word_idx_n = '0;
          acc_n      = '0;
          pk_clear   = 1'b1;
        end
      end
      LEN: begin
        if (xfer) begin
          acc_n = in_data;
          if (in_data == 8'd0 || in_data > MAX_L) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else begin
            len_m1_n = WIDX_W'(in_data - 8'd1);
            state_n  = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          acc_n = acc ^ in_data;
          if (pk_complete) begin
            state_n     = WRITE;
            mem_we_n    = 1'b1;
            mem_addr_n  = {word_idx, 2'b00};
            mem_wdata_n = {pk_word[23:0], in_data};
          end
        end
      end
      WRITE: begin
        word_idx_n = word_idx + WIDX_W'(1);
        state_n    = (word_idx == len_m1) ? CSUM : DATA;
      end
      CSUM: begin
        if (xfer) begin
          err_n   = (in_data != acc);
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == LEN) || (state_n == DATA) || (state_n == WRITE) || (state_n == CSUM);
    done_n = (state_n == DONE);
    hold_n = !((state_n == DONE) && !err_n);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_idx  <= '0;
      len_m1    <= '0;
      acc       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_hold  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      word_idx  <= word_idx_n;
      len_m1    <= len_m1_n;
      acc       <= acc_n;
      err       <= err_n;
      busy      <= busy_n;
      done      <= done_n;
      cpu_hold  <= hold_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end

endmodule
